// File: rtl/zimbo_timer.sv
// Memory-mapped timer/counter for the Zimbo data-memory port: prescaled down-counter with auto-reload,
// sticky expiry/irq, and an optional 32-bit cycle counter enabled by `define ZIMBO_TIMER_CYCLE_CNT_EN.
module zimbo_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addrm,
    input  logic [15:0] wmdata,
    input  logic        memwr_en,
    output logic        periph_sel,
    output logic [15:0] periph_rdata,
    output logic        irq
);

    // state  | meaning
    // IDLE   | disabled, COUNT and prescaler frozen
    // RUN    | prescaler running, COUNT decrements on each tick
    // DONE   | one-shot expired, COUNT parked at 0 until re-armed
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_nx;
    logic        ctrl_en_q, ctrl_ar_q, ctrl_ie_q;
    logic [7:0]  ctrl_pre_q;
    logic [15:0] load_q;
    logic [15:0] count_q, count_nx;
    logic [7:0]  ps_q, ps_nx;
    logic        exp_q, exp_nx;

    logic [15:0] off;
    logic        in_win;
    logic        wr_ctrl, wr_load, wr_count, wr_status;
    logic        tick, expiry;

    assign off       = addrm - BASE_ADDR;
    assign in_win    = (off[15:3] == 13'd0);
    assign wr_ctrl   = memwr_en && in_win && (off[2:0] == 3'd0);
    assign wr_load   = memwr_en && in_win && (off[2:0] == 3'd1);
    assign wr_count  = memwr_en && in_win && (off[2:0] == 3'd2);
    assign wr_status = memwr_en && in_win && (off[2:0] == 3'd3);
    assign tick      = (state_q == S_RUN) && (ps_q == ctrl_pre_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ps_q    <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            count_q <= count_nx;
            ps_q    <= ps_nx;
            exp_q   <= exp_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        count_nx = count_q;
        ps_nx    = ps_q;
        expiry   = 1'b0;
        case (state_q)
            S_RUN: begin
                // a disable write suppresses whatever the tick would have done
                if (wr_ctrl && !wmdata[0]) begin
                    state_nx = S_IDLE;
                end else if (tick) begin
                    ps_nx = '0;
                    if (count_q != 16'd0) begin
                        count_nx = count_q - 16'd1;
                    end else begin
                        expiry = 1'b1;
                        if (ctrl_ar_q) count_nx = load_q;
                        else           state_nx = S_DONE;
                    end
                end else begin
                    ps_nx = ps_q + 8'd1;
                end
            end
            default: begin
                if (wr_ctrl) begin
                    if (wmdata[0]) begin
                        state_nx = S_RUN;
                        count_nx = load_q;
                        ps_nx    = '0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
        endcase
        if (wr_count) count_nx = wmdata;
        exp_nx = expiry || (exp_q && !(wr_status && wmdata[0]));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en_q  <= 1'b0;
            ctrl_ar_q  <= 1'b0;
            ctrl_ie_q  <= 1'b0;
            ctrl_pre_q <= '0;
            load_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q  <= wmdata[0];
                ctrl_ar_q  <= wmdata[1];
                ctrl_ie_q  <= wmdata[2];
                ctrl_pre_q <= wmdata[15:8];
            end
            if (wr_load) load_q <= wmdata;
        end
    end

`ifdef ZIMBO_TIMER_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    logic [15:0] cyc_hi_q;
    logic        addr_cyc_lo;

    assign addr_cyc_lo = in_win && (off[2:0] == 3'd4);

    // reading LO snapshots the upper half so a following HI read is coherent
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q    <= '0;
            cyc_hi_q <= '0;
        end else if (addr_cyc_lo && memwr_en) begin
            cyc_q    <= '0;
            cyc_hi_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (addr_cyc_lo) cyc_hi_q <= cyc_q[31:16];
        end
    end
`endif

    always_comb begin
        periph_sel   = 1'b0;
        periph_rdata = '0;
        if (in_win) begin
            case (off[2:0])
                3'd0: begin
                    periph_sel   = 1'b1;
                    periph_rdata = {ctrl_pre_q, 5'b0, ctrl_ie_q, ctrl_ar_q, ctrl_en_q};
                end
                3'd1: begin
                    periph_sel   = 1'b1;
                    periph_rdata = load_q;
                end
                3'd2: begin
                    periph_sel   = 1'b1;
                    periph_rdata = count_q;
                end
                3'd3: begin
                    periph_sel   = 1'b1;
                    periph_rdata = {15'b0, exp_q};
                end
`ifdef ZIMBO_TIMER_CYCLE_CNT_EN
                3'd4: begin
                    periph_sel   = 1'b1;
                    periph_rdata = cyc_q[15:0];
                end
                3'd5: begin
                    periph_sel   = 1'b1;
                    periph_rdata = cyc_hi_q;
                end
`endif
                default: begin
                    periph_sel   = 1'b0;
                    periph_rdata = '0;
                end
            endcase
        end
    end

    assign irq = exp_q && ctrl_ie_q;

endmodule

// File: tb/tb_zimbo_timer.sv
// Bench for zimbo_timer: directed scenarios plus random bus traffic, scoreboard-checked
// against a behavioural model of the register map and timer rules.
module tb_zimbo_timer;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] addrm;
    logic [15:0] wmdata;
    logic        memwr_en;
    logic        periph_sel;
    logic [15:0] periph_rdata;
    logic        irq;

    zimbo_timer #(.BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .addrm        (addrm),
        .wmdata       (wmdata),
        .memwr_en     (memwr_en),
        .periph_sel   (periph_sel),
        .periph_rdata (periph_rdata),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        sel;
        logic [15:0] data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic rd_strobe = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // behavioural reference: mode 0 = stopped, 1 = counting, 2 = one-shot finished
    int          m_mode;
    logic        m_en, m_ar, m_ie, m_exp;
    logic [7:0]  m_pre, m_ps;
    logic [15:0] m_load, m_count, m_shadow;
    logic [31:0] m_cyc;

    task automatic model_reset();
        m_mode = 0; m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_pre = 0; m_ps = 0; m_load = 0; m_count = 0; m_shadow = 0; m_cyc = 0;
    endtask

    task automatic model_read(input logic [15:0] a, output logic sel, output logic [15:0] d);
        logic [15:0] o;
        o = a - BASE;
        sel = 1'b1;
        d = 16'h0000;
        if (o == 16'd0)      d = {m_pre, 5'b0, m_ie, m_ar, m_en};
        else if (o == 16'd1) d = m_load;
        else if (o == 16'd2) d = m_count;
        else if (o == 16'd3) d = {15'b0, m_exp};
`ifdef ZIMBO_TIMER_CYCLE_CNT_EN
        else if (o == 16'd4) d = m_cyc[15:0];
        else if (o == 16'd5) d = m_shadow;
`endif
        else sel = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] o, cnt_n;
        logic [7:0]  ps_n;
        logic        fire, exp_n;
        int          mode_n;
        o = a - BASE;
        cnt_n = m_count; ps_n = m_ps; mode_n = m_mode; fire = 0;
        if (m_mode == 1) begin
            if (m_ps == m_pre) begin
                ps_n = 0;
                if (m_count > 0) cnt_n = m_count - 16'd1;
                else begin
                    fire = 1;
                    if (m_ar) cnt_n = m_load;
                    else mode_n = 2;
                end
            end else ps_n = m_ps + 8'd1;
        end
        exp_n = m_exp | fire;
        if (we) begin
            if (o == 16'd0) begin
                if (!d[0]) begin
                    mode_n = 0; cnt_n = m_count; ps_n = m_ps; exp_n = m_exp;
                end else if (m_mode != 1) begin
                    mode_n = 1; cnt_n = m_load; ps_n = 0;
                end
                m_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_pre = d[15:8];
            end
            else if (o == 16'd1) m_load = d;
            else if (o == 16'd2) cnt_n = d;
            else if (o == 16'd3 && d[0]) exp_n = fire;
        end
`ifdef ZIMBO_TIMER_CYCLE_CNT_EN
        if (we && o == 16'd4) begin
            m_cyc = 0; m_shadow = 0;
        end else begin
            if (o == 16'd4) m_shadow = m_cyc[31:16];
            m_cyc = m_cyc + 32'd1;
        end
`endif
        m_count = cnt_n; m_ps = ps_n; m_mode = mode_n; m_exp = exp_n;
    endtask

    // one bus cycle: drive, let the monitor sample at negedge, commit at posedge
    task automatic bus(input logic we, input logic [15:0] a, input logic [15:0] d);
        addrm = a; wmdata = d; memwr_en = we;
        @(negedge clock);
        @(posedge clock);
        if (reset_n) model_step(we, a, d);
        else model_reset();
        #1;
    endtask

    function automatic logic [15:0] adr(input int o);
        return BASE + 16'(o);
    endfunction

    task automatic wr(input int o, input logic [15:0] d);
        bus(1'b1, adr(o), d);
    endtask

    task automatic idle();
        bus(1'b0, 16'h1234, 16'h0000);
    endtask

    task automatic chk_const(input logic [15:0] a, input logic sel, input logic [15:0] d,
                             input logic irq_e, input string name);
        exp_t e;
        e.sel = sel; e.data = d; e.irq = irq_e; e.name = name;
        sb_q.push_back(e);
        rd_strobe = 1'b1;
        bus(1'b0, a, 16'h0000);
        rd_strobe = 1'b0;
    endtask

    task automatic chk_model(input logic [15:0] a, input string name);
        exp_t e;
        model_read(a, e.sel, e.data);
        e.irq = m_exp & m_ie;
        e.name = name;
        sb_q.push_back(e);
        rd_strobe = 1'b1;
        bus(1'b0, a, 16'h0000);
        rd_strobe = 1'b0;
    endtask

    always @(negedge clock) begin
        if (rd_strobe) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: read at addr %h with no expected entry", addrm);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (periph_sel !== e.sel || periph_rdata !== e.data || irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s addr=%h: got sel=%b rdata=%h irq=%b, want sel=%b rdata=%h irq=%b",
                             e.name, addrm, periph_sel, periph_rdata, irq, e.sel, e.data, e.irq);
                end
            end
        end
    end

    initial begin
        logic [15:0] a, d;
        int r, o;

        model_reset();
        reset_n = 1'b0; addrm = BASE; wmdata = '0; memwr_en = 1'b0;
        chk_const(BASE, 1, 16'h0000, 0, "rst_sel");
        chk_const(adr(3), 1, 16'h0000, 0, "rst_status");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) chk_const(adr(i), 1, 16'h0000, 0, "post_rst");

        // one-shot, LOAD=3
        wr(1, 16'd3);
        wr(0, 16'h0005);
        repeat (3) idle();
        chk_const(adr(3), 1, 16'h0000, 0, "os_not_yet");
        chk_const(adr(3), 1, 16'h0001, 1, "os_expired");
        chk_const(adr(0), 1, 16'h0005, 1, "os_ctrl_rb");
        for (int i = 0; i < 20; i++) chk_const(adr(2), 1, 16'h0000, 1, "os_count_hold");
        wr(3, 16'h0001);
        chk_const(adr(3), 1, 16'h0000, 0, "os_clear");

        // auto-reload, PRE=1, LOAD=1: expiry every 4 clocks
        wr(1, 16'd1);
        wr(0, 16'h0103);
        repeat (3) idle();
        chk_const(adr(3), 1, 16'h0000, 0, "ar_not_yet");
        chk_const(adr(3), 1, 16'h0001, 0, "ar_exp1");
        wr(3, 16'h0001);
        chk_const(adr(3), 1, 16'h0000, 0, "ar_cleared");
        chk_const(adr(3), 1, 16'h0000, 0, "ar_cleared2");
        chk_const(adr(3), 1, 16'h0001, 0, "ar_exp2");
        idle();
        idle();
        wr(3, 16'h0001);
        chk_const(adr(3), 1, 16'h0001, 0, "clr_vs_set");
        wr(2, 16'h0010);
        chk_const(adr(2), 1, 16'h0010, 0, "cnt_wr_tick");

        // disable mid-run
        wr(0, 16'h0000);
        wr(1, 16'd100);
        wr(0, 16'h0001);
        repeat (10) idle();
        wr(0, 16'h0000);
        chk_const(adr(2), 1, 16'd90, 0, "dis_count");
        repeat (5) idle();
        chk_const(adr(2), 1, 16'd90, 0, "dis_frozen");
        wr(0, 16'h0001);
        chk_const(adr(2), 1, 16'd100, 0, "reen_reload");

        // LOAD=0 with auto-reload expires on every tick
        wr(0, 16'h0000);
        wr(3, 16'h0001);
        wr(1, 16'd0);
        wr(0, 16'h0007);
        chk_const(adr(3), 1, 16'h0000, 0, "l0_not_yet");
        chk_const(adr(3), 1, 16'h0001, 1, "l0_exp");
        wr(3, 16'h0001);
        chk_const(adr(3), 1, 16'h0001, 1, "l0_set_wins");
        chk_const(adr(2), 1, 16'h0000, 1, "l0_count");

        // out-of-window decode
        chk_const(16'hFEFF, 0, 16'h0000, 1, "win_below");
        chk_const(16'hFF08, 0, 16'h0000, 1, "win_above");
        chk_const(adr(6), 0, 16'h0000, 1, "off6");
        chk_const(adr(7), 0, 16'h0000, 1, "off7");

        // reset in the middle of a count
        wr(0, 16'h0000);
        wr(3, 16'h0001);
        wr(1, 16'd50);
        wr(0, 16'h0005);
        repeat (5) idle();
        reset_n = 1'b0;
        model_reset();
        chk_const(adr(2), 1, 16'h0000, 0, "rst_mid_count");
        chk_const(adr(0), 1, 16'h0000, 0, "rst_mid_ctrl");
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) chk_const(adr(i), 1, 16'h0000, 0, "rst_mid_regs");
        repeat (60) idle();
        chk_const(adr(3), 1, 16'h0000, 0, "rst_no_expiry");
        chk_const(adr(2), 1, 16'h0000, 0, "rst_count_idle");

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            o = $urandom_range(0, 7);
            if (r < 30) begin
                case (o)
                    0: d = {8'($urandom_range(0, 2)), 5'($urandom), 1'($urandom), 1'($urandom),
                            ($urandom_range(0, 3) != 0)};
                    1: d = 16'($urandom_range(0, 6));
                    2: d = 16'($urandom_range(0, 8));
                    default: d = 16'($urandom);
                endcase
                if (o == 4 && $urandom_range(0, 9) != 0) d = 16'h0000;
                if (o == 4 && d != 16'h0000) wr(1, d);
                else wr(o, d);
            end else if (r < 85) begin
                chk_model(adr(o), "rand_read");
            end else if (r < 92) begin
                case ($urandom_range(0, 3))
                    0: a = 16'hFEFF;
                    1: a = 16'hFF08;
                    2: a = 16'h0000;
                    default: a = 16'h7F03;
                endcase
                chk_model(a, "rand_outside");
            end else begin
                idle();
            end
        end

        wr(0, 16'h0000);
        wr(3, 16'h0001);
`ifdef ZIMBO_TIMER_CYCLE_CNT_EN
        wr(4, 16'h0000);
        repeat (70000) idle();
        chk_const(adr(4), 1, 16'h1170, 0, "cyc_lo");
        chk_const(adr(5), 1, 16'h0001, 0, "cyc_hi");
        chk_model(adr(4), "cyc_lo_model");
        wr(5, 16'hFFFF);
        chk_model(adr(5), "cyc_hi_nowrite");
`else
        chk_const(adr(4), 0, 16'h0000, 0, "cyc_lo_absent");
        chk_const(adr(5), 0, 16'h0000, 0, "cyc_hi_absent");
`endif

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
